mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 23 ++
 rtl/mdu_ctrl_if.sv | 28 ++
 rtl/md_calc.sv | 61 ++++++
 rtl/mdu_ctrl.sv | 115 +++++++++++
 tb/tb_mdu_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op encodings and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mdu_ctrl_pkg;

    // md_op encodings driven by the decoder
    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    // Sequencer states
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    // True for the two divide encodings
    function automatic logic isDivOp(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> multiply/divide unit signal bundle.
// Latency: n/a (wiring only).
// Backpressure: stall_req flows back to the pipeline; there is no other handshake.
interface mdu_ctrl_if;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        wr_hi;
    logic        wr_lo;
    logic        md_use_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    // Pipeline side
    modport master (
        output start, md_op, rs_val, rt_val, wr_hi, wr_lo, md_use_d,
        input  hi, lo, busy, stall_req
    );

    // Multiply/divide unit side
    modport slave (
        input  start, md_op, rs_val, rt_val, wr_hi, wr_lo, md_use_d,
        output hi, lo, busy, stall_req
    );
endinterface

// File: rtl/md_calc.sv
// Combinational 32x32 multiply (signed/unsigned) and divide (signed/unsigned).
// Latency: zero cycles; the sequencer models the multi-cycle timing.
// Backpressure: none; results are valid whenever inputs are stable.
module md_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div0
);

    logic [63:0] aExt;
    logic [63:0] bExt;
    logic [63:0] prod;
    logic        signedOp;
    logic        aNeg;
    logic        bNeg;
    logic [31:0] aMag;
    logic [31:0] bMag;
    logic [31:0] bSafe;
    logic [31:0] qMag;
    logic [31:0] rMag;

    // Operand conditioning: sign extension for multiply, magnitudes for divide
    always_comb begin
        signedOp = (op == MD_MULT) || (op == MD_DIV);
        aNeg     = signedOp & a[31];
        bNeg     = signedOp & b[31];
        aExt     = {{32{aNeg}}, a};
        bExt     = {{32{bNeg}}, b};
        aMag     = aNeg ? (~a + 32'd1) : a;
        bMag     = bNeg ? (~b + 32'd1) : b;
        // Keep the divider free of X when the divisor is zero; result is discarded anyway
        bSafe    = (bMag == 32'd0) ? 32'd1 : bMag;
    end

    // Low 64 bits of the extended product equal the signed/unsigned 64-bit product.
    // Divide works on magnitudes so truncation is toward zero; 0x80000000 / -1
    // naturally yields quotient 0x80000000, remainder 0.
    always_comb begin
        prod   = aExt * bExt;
        qMag   = aMag / bSafe;
        rMag   = aMag % bSafe;
        div0   = isDivOp(op) && (b == 32'd0);
        hi_res = 32'd0;
        lo_res = 32'd0;
        if (isDivOp(op)) begin
            if (!div0) begin
                lo_res = (aNeg ^ bNeg) ? (~qMag + 32'd1) : qMag;
                hi_res = aNeg ? (~rMag + 32'd1) : rMag;
            end
        end else begin
            hi_res = prod[63:32];
            lo_res = prod[31:0];
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS HI/LO multiply/divide controller: computes at start, commits after a fixed busy period.
// Latency: MUL_CYCLES / DIV_CYCLES busy cycles after start; mthi/mtlo land on the next edge.
// Backpressure: stall_req = md_use_d & (busy | start) freezes the front end while an op runs.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  mdu
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    mdState_t    state;
    mdState_t    nextState;
    logic [3:0]  cnt;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic [31:0] pendHi;
    logic [31:0] pendLo;
    logic        pendWr;
    logic        busyInt;
    logic        loadOp;
    logic        commit;
    logic        mtAllowed;
    logic [31:0] hiRes;
    logic [31:0] loRes;
    logic        div0;

    md_calc u_calc (
        .op     (mdu.md_op),
        .a      (mdu.rs_val),
        .b      (mdu.rt_val),
        .hi_res (hiRes),
        .lo_res (loRes),
        .div0   (div0)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: leave IDLE on start, return when the last busy cycle ends
    always_comb begin
        nextState = state;
        case (state)
            MD_IDLE: if (mdu.start)      nextState = MD_BUSY;
            MD_BUSY: if (cnt == 4'd1)    nextState = MD_IDLE;
            default:                     nextState = MD_IDLE;
        endcase
    end

    // Outputs / strobes decoded from state; start wins over mthi/mtlo in IDLE
    always_comb begin
        busyInt   = (state == MD_BUSY);
        loadOp    = (state == MD_IDLE) && mdu.start;
        commit    = (state == MD_BUSY) && (cnt == 4'd1);
        mtAllowed = (state == MD_IDLE) && !mdu.start;
    end

    // Busy-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (loadOp) begin
            cnt <= isDivOp(mdu.md_op) ? DIV_LOAD : MUL_LOAD;
        end else if (busyInt) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Pending result captured at start; a zero divisor suppresses the later commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendHi <= 32'd0;
            pendLo <= 32'd0;
            pendWr <= 1'b0;
        end else if (loadOp) begin
            pendHi <= hiRes;
            pendLo <= loRes;
            pendWr <= !div0;
        end
    end

    // Architectural HI/LO: commit at end of op, or mthi/mtlo while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hiReg <= 32'd0;
            loReg <= 32'd0;
        end else if (commit) begin
            if (pendWr) begin
                hiReg <= pendHi;
                loReg <= pendLo;
            end
        end else if (mtAllowed) begin
            if (mdu.wr_hi) hiReg <= mdu.rs_val;
            if (mdu.wr_lo) loReg <= mdu.rs_val;
        end
    end

    assign mdu.hi        = hiReg;
    assign mdu.lo        = loReg;
    assign mdu.busy      = busyInt;
    assign mdu.stall_req = mdu.md_use_d & (busyInt | mdu.start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: op results, busy lengths, mthi/mtlo, stall, reset abort.
// Latency: checks busy duration against MUL_CYCLES=5 / DIV_CYCLES=10.
// Backpressure: checks stall_req against md_use_d each cycle.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mdu_ctrl_if mif();

    mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and count busy cycles (bounded)
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic useD, output int n);
        mif.start    = 1'b1;
        mif.md_op    = op;
        mif.rs_val   = a;
        mif.rt_val   = b;
        mif.md_use_d = useD;
        tick();
        mif.start = 1'b0;
        n = 0;
        while (mif.busy && n < 40) begin
            n++;
            tick();
        end
        mif.md_use_d = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (mif.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", mif.hi); end
        checks++; if (mif.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", mif.lo); end
        checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mif.busy); end
        checks++; if (mif.stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", mif.stall_req); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        runOp(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, n);
        checks++; if (n !== 5) begin failures++; $display("FAIL mult_cycles got=%0d exp=5", n); end
        checks++; if (mif.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", mif.hi); end
        checks++; if (mif.lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", mif.lo); end
        runOp(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, n);
        checks++; if (mif.hi !== 32'h00000001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", mif.hi); end
        checks++; if (mif.lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", mif.lo); end
    endtask

    task automatic test_div();
        int n;
        runOp(MD_DIVU, 32'd100, 32'd7, 1'b0, n);
        checks++; if (n !== 10) begin failures++; $display("FAIL divu_cycles got=%0d exp=10", n); end
        checks++; if (mif.lo !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=0000000e", mif.lo); end
        checks++; if (mif.hi !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=00000002", mif.hi); end
        runOp(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, n);
        checks++; if (mif.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=fffffffd", mif.lo); end
        checks++; if (mif.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=ffffffff", mif.hi); end
        runOp(MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, n);
        checks++; if (mif.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negb_lo got=%h exp=fffffffd", mif.lo); end
        checks++; if (mif.hi !== 32'd1) begin failures++; $display("FAIL div_negb_hi got=%h exp=00000001", mif.hi); end
        runOp(MD_DIVU, 32'hFFFFFFF9, 32'd2, 1'b0, n);
        checks++; if (mif.lo !== 32'h7FFFFFFC) begin failures++; $display("FAIL divu_big_lo got=%h exp=7ffffffc", mif.lo); end
        checks++; if (mif.hi !== 32'd1) begin failures++; $display("FAIL divu_big_hi got=%h exp=00000001", mif.hi); end
        runOp(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, n);
        checks++; if (mif.lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", mif.lo); end
        checks++; if (mif.hi !== 32'd0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=00000000", mif.hi); end
    endtask

    task automatic test_mt_and_div0();
        int n;
        mif.rs_val = 32'h0000ABCD;
        mif.wr_hi  = 1'b1;
        tick();
        mif.wr_hi  = 1'b0;
        checks++; if (mif.hi !== 32'h0000ABCD) begin failures++; $display("FAIL mthi got=%h exp=0000abcd", mif.hi); end
        mif.rs_val = 32'h11;
        mif.wr_hi  = 1'b1;
        tick();
        mif.wr_hi  = 1'b0;
        mif.rs_val = 32'h22;
        mif.wr_lo  = 1'b1;
        tick();
        mif.wr_lo  = 1'b0;
        checks++; if (mif.lo !== 32'h22) begin failures++; $display("FAIL mtlo got=%h exp=00000022", mif.lo); end
        runOp(MD_DIV, 32'd55, 32'd0, 1'b0, n);
        checks++; if (n !== 10) begin failures++; $display("FAIL div0_cycles got=%0d exp=10", n); end
        checks++; if (mif.hi !== 32'h11) begin failures++; $display("FAIL div0_hi got=%h exp=00000011", mif.hi); end
        checks++; if (mif.lo !== 32'h22) begin failures++; $display("FAIL div0_lo got=%h exp=00000022", mif.lo); end
    endtask

    task automatic test_start_priority();
        int n;
        mif.wr_lo = 1'b1;
        mif.wr_hi = 1'b1;
        runOp(MD_MULTU, 32'd3, 32'd5, 1'b0, n);
        mif.wr_lo = 1'b0;
        mif.wr_hi = 1'b0;
        checks++; if (mif.lo !== 32'd15) begin failures++; $display("FAIL prio_lo got=%h exp=0000000f", mif.lo); end
        checks++; if (mif.hi !== 32'd0) begin failures++; $display("FAIL prio_hi got=%h exp=00000000", mif.hi); end
    endtask

    task automatic test_ignore_busy();
        int n;
        mif.start  = 1'b1;
        mif.md_op  = MD_MULTU;
        mif.rs_val = 32'd2;
        mif.rt_val = 32'd3;
        tick();
        // Inputs that must be ignored while busy
        mif.md_op  = MD_DIVU;
        mif.rs_val = 32'h0000DEAD;
        mif.rt_val = 32'd1;
        mif.wr_hi  = 1'b1;
        mif.wr_lo  = 1'b1;
        n = 0;
        while (mif.busy && n < 40) begin
            n++;
            if (n == 3) begin
                mif.start = 1'b0;
                mif.wr_hi = 1'b0;
                mif.wr_lo = 1'b0;
            end
            tick();
        end
        mif.start = 1'b0;
        mif.wr_hi = 1'b0;
        mif.wr_lo = 1'b0;
        checks++; if (n !== 5) begin failures++; $display("FAIL busy_ign_cycles got=%0d exp=5", n); end
        checks++; if (mif.lo !== 32'd6) begin failures++; $display("FAIL busy_ign_lo got=%h exp=00000006", mif.lo); end
        checks++; if (mif.hi !== 32'd0) begin failures++; $display("FAIL busy_ign_hi got=%h exp=00000000", mif.hi); end
    endtask

    task automatic test_stall();
        mif.start    = 1'b1;
        mif.md_op    = MD_MULT;
        mif.rs_val   = 32'd4;
        mif.rt_val   = 32'd4;
        mif.md_use_d = 1'b1;
        #1;
        checks++; if (mif.stall_req !== 1'b1) begin failures++; $display("FAIL stall_start got=%b exp=1", mif.stall_req); end
        tick();
        mif.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (mif.busy !== 1'b1) begin failures++; $display("FAIL stall_busy%0d got=%b exp=1", i, mif.busy); end
            checks++; if (mif.stall_req !== 1'b1) begin failures++; $display("FAIL stall_cyc%0d got=%b exp=1", i, mif.stall_req); end
            tick();
        end
        checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL stall_idle_busy got=%b exp=0", mif.busy); end
        checks++; if (mif.stall_req !== 1'b0) begin failures++; $display("FAIL stall_idle got=%b exp=0", mif.stall_req); end
        checks++; if (mif.lo !== 32'd16) begin failures++; $display("FAIL stall_lo got=%h exp=00000010", mif.lo); end
        mif.md_use_d = 1'b0;
        mif.start    = 1'b1;
        tick();
        mif.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (mif.stall_req !== 1'b0) begin failures++; $display("FAIL nouse_cyc%0d got=%b exp=0", i, mif.stall_req); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        mif.start  = 1'b1;
        mif.md_op  = MD_DIVU;
        mif.rs_val = 32'd100;
        mif.rt_val = 32'd7;
        tick();
        mif.start = 1'b0;
        tick();
        tick();
        // third busy cycle
        checks++; if (mif.busy !== 1'b1) begin failures++; $display("FAIL rmid_pre_busy got=%b exp=1", mif.busy); end
        reset = 1'b1;
        mif.md_use_d = 1'b1;
        #1;
        checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", mif.busy); end
        checks++; if (mif.hi !== 32'd0) begin failures++; $display("FAIL rmid_hi got=%h exp=00000000", mif.hi); end
        checks++; if (mif.lo !== 32'd0) begin failures++; $display("FAIL rmid_lo got=%h exp=00000000", mif.lo); end
        checks++; if (mif.stall_req !== 1'b0) begin failures++; $display("FAIL rmid_stall got=%b exp=0", mif.stall_req); end
        mif.start = 1'b1;
        #1;
        checks++; if (mif.stall_req !== 1'b1) begin failures++; $display("FAIL rmid_stall_start got=%b exp=1", mif.stall_req); end
        mif.start    = 1'b0;
        mif.md_use_d = 1'b0;
        tick();
        reset = 1'b0;
        repeat (12) tick();
        checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL rmid_after_busy got=%b exp=0", mif.busy); end
        checks++; if (mif.hi !== 32'd0) begin failures++; $display("FAIL rmid_after_hi got=%h exp=00000000", mif.hi); end
        checks++; if (mif.lo !== 32'd0) begin failures++; $display("FAIL rmid_after_lo got=%h exp=00000000", mif.lo); end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        mif.start    = 1'b0;
        mif.md_op    = 2'd0;
        mif.rs_val   = 32'd0;
        mif.rt_val   = 32'd0;
        mif.wr_hi    = 1'b0;
        mif.wr_lo    = 1'b0;
        mif.md_use_d = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mt_and_div0();
        test_start_priority();
        test_ignore_busy();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
